// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the single-cycle MIPS front end:
// next-PC select encodings, fetch FSM states and instruction field slices.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JR     = 2'b10,
        PC_JUMP   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_e;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// Next-PC target selection plus alignment / ROM-range validity check.
// Purely combinational.
module next_pc_mux
    import cpu_defs_pkg::*;
#(
    parameter int ROM_BYTES = 100
) (
    input  logic [31:0] pc4,
    input  logic [1:0]  pc_src,
    input  logic [31:0] ext_imm,
    input  logic [31:0] reg_rs,
    input  logic [25:0] j_addr,
    output logic [31:0] target,
    output logic        bad
);

    logic [32:0] last_byte;

    always_comb begin
        target = pc4;
        unique case (pc_src)
            PC_SEQ:    target = pc4;
            PC_BRANCH: target = pc4 + (ext_imm << 2);
            PC_JR:     target = reg_rs;
            PC_JUMP:   target = {pc4[31:28], j_addr, 2'b00};
            default:   target = pc4;
        endcase
    end

    // 33-bit sum so a carry out of bit 31 counts as out of range
    assign last_byte = {1'b0, target} + 33'd3;

    assign bad = (target[1:0] != 2'b00) || (last_byte >= 33'(ROM_BYTES));

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, fetch FSM (RUN/HALT/FAULT) and fetched-instruction
// counter feeding the instruction ROM address.
module pc_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ROM_BYTES   = 100,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ExtImm,
    input  logic [31:0] RegRs,
    input  logic [25:0] JAddr,
    input  logic [31:0] Ins,
    output logic [31:0] CurPC,
    output logic [31:0] PC4,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] InsCount
);

    fetch_state_e state;
    logic [31:0]  target;
    logic         bad;
    logic         is_halt;
    logic         unused_ins;

    assign PC4        = CurPC + 32'd4;
    assign is_halt    = (Ins[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
    assign unused_ins = ^Ins[OPCODE_LSB-1:0];

    next_pc_mux #(
        .ROM_BYTES(ROM_BYTES)
    ) u_next_pc_mux (
        .pc4    (PC4),
        .pc_src (PCSrc),
        .ext_imm(ExtImm),
        .reg_rs (RegRs),
        .j_addr (JAddr),
        .target (target),
        .bad    (bad)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_RUN;
            CurPC    <= RESET_PC;
            InsCount <= 32'd0;
            Halted   <= 1'b0;
            Fault    <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    // halt wins over stall and over a bad target
                    if (is_halt) begin
                        state  <= ST_HALT;
                        Halted <= 1'b1;
                    end else if (PCWre) begin
                        if (bad) begin
                            state <= ST_FAULT;
                            Fault <= 1'b1;
                        end else begin
                            CurPC    <= target;
                            InsCount <= InsCount + 32'd1;
                        end
                    end
                end
                ST_HALT: begin
                    Halted <= 1'b1;
                    Fault  <= 1'b0;
                end
                ST_FAULT: begin
                    Halted <= 1'b0;
                    Fault  <= 1'b1;
                end
                default: begin
                    state  <= ST_FAULT;
                    Halted <= 1'b0;
                    Fault  <= 1'b1;
                end
            endcase
        end
    end

endmodule
